// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, EX/MEM pipeline register, and an
// iterative 32-cycle multiply/divide unit with HI/LO registers.
module exe_stage #(
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          wbi,
    input  logic                Mi,
    input  logic [4:0]          regaddr,
    input  logic                nop_id,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         opa,
    input  logic [31:0]         opb,
    input  logic [31:0]         store_data,
    input  logic [2:0]          md_op,
    output logic [1:0]          wbo,
    output logic                M,
    output logic [31:0]         data,
    output logic [31:0]         dataaddr,
    output logic [4:0]          regaddrout,
    output logic                nop_exe,
    output logic                stall,
    output logic                md_busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} md_state_t;

    md_state_t   state_q, state_d;
    logic [31:0] hi_q, lo_q, mcand_q, raw_a_q;
    logic [63:0] acc_q;
    logic [5:0]  cnt_q;
    logic        neg_q, nega_q, dz_q, is_div_q;

    // mult/div request decode
    logic        md_any, md_start, md_signed, sa, sb, accept;
    logic [31:0] abs_a, abs_b;

    assign md_any    = (md_op >= 3'd1) && (md_op <= 3'd6);
    assign md_start  = (md_op >= 3'd1) && (md_op <= 3'd4);
    assign md_signed = (md_op == 3'd1) || (md_op == 3'd3);
    assign sa        = md_signed & opa[31];
    assign sb        = md_signed & opb[31];
    assign abs_a     = sa ? (32'd0 - opa) : opa;
    assign abs_b     = sb ? (32'd0 - opb) : opb;

    assign md_busy   = (state_q != S_IDLE);
    assign stall     = md_busy & ~nop_id & md_any;
    assign accept    = ~md_busy & ~nop_id & md_start;

    // one iteration of shift-add multiply and restoring divide
    logic [32:0] mul_sum, div_rem, div_sub;
    logic        div_ge;
    logic [63:0] mul_next, div_next, prod;
    logic [31:0] quo, rem;

    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};
    assign div_rem  = acc_q[63:31];
    assign div_ge   = (div_rem >= {1'b0, mcand_q});
    assign div_sub  = div_rem - {1'b0, mcand_q};
    assign div_next = {(div_ge ? div_sub[31:0] : div_rem[31:0]), acc_q[30:0], div_ge};
    assign prod     = neg_q  ? (64'd0 - acc_q) : acc_q;
    assign quo      = neg_q  ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
    assign rem      = nega_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    // mult/div state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // mult/div next state: 32 iterations then a sign-fix cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (md_op >= 3'd3) ? S_DIV : S_MUL;
            S_MUL,
            S_DIV:   if (cnt_q == 6'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // mult/div datapath and HI/LO; a reset mid-operation drops the result
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0; lo_q <= '0; acc_q <= '0; mcand_q <= '0; raw_a_q <= '0;
            cnt_q <= '0; neg_q <= 1'b0; nega_q <= 1'b0; dz_q <= 1'b0; is_div_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    acc_q    <= {32'd0, abs_a};
                    mcand_q  <= abs_b;
                    raw_a_q  <= opa;
                    neg_q    <= sa ^ sb;
                    nega_q   <= sa;
                    dz_q     <= (opb == 32'd0);
                    is_div_q <= (md_op >= 3'd3);
                    cnt_q    <= '0;
                end
                S_MUL: begin acc_q <= mul_next; cnt_q <= cnt_q + 6'd1; end
                S_DIV: begin acc_q <= div_next; cnt_q <= cnt_q + 6'd1; end
                S_FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod[63:32]; lo_q <= prod[31:0];
                    end else if (dz_q) begin
                        // divide by zero: HI keeps the dividend, LO all ones
                        hi_q <= raw_a_q; lo_q <= 32'hFFFF_FFFF;
                    end else begin
                        hi_q <= rem; lo_q <= quo;
                    end
                end
                default: ;
            endcase
        end
    end

    // single-cycle ALU, unlisted codes give zero
    logic [31:0] alu_res, exe_res;
    always_comb begin
        alu_res = '0;
        case (int'(alu_op))
            0:  alu_res = opa + opb;
            1:  alu_res = opa - opb;
            2:  alu_res = opa & opb;
            3:  alu_res = opa | opb;
            4:  alu_res = opa ^ opb;
            5:  alu_res = ~(opa | opb);
            6:  alu_res = {31'd0, ($signed(opa) < $signed(opb))};
            7:  alu_res = {31'd0, (opa < opb)};
            8:  alu_res = opb << opa[4:0];
            9:  alu_res = opb >> opa[4:0];
            10: alu_res = $signed(opb) >>> opa[4:0];
            11: alu_res = {opb[15:0], 16'd0};
            default: alu_res = '0;
        endcase
    end

    assign exe_res = (md_op == 3'd5) ? hi_q :
                     (md_op == 3'd6) ? lo_q : alu_res;

    // EX/MEM register; bubbles clear control but hold data/address
    always_ff @(posedge clk) begin
        if (reset) begin
            wbo <= '0; M <= 1'b0; data <= '0; dataaddr <= '0;
            regaddrout <= '0; nop_exe <= 1'b1;
        end else if (nop_id || stall) begin
            wbo <= '0; M <= 1'b0; regaddrout <= '0; nop_exe <= 1'b1;
        end else begin
            wbo        <= wbi;
            M          <= Mi;
            data       <= store_data;
            dataaddr   <= exe_res;
            regaddrout <= regaddr;
            nop_exe    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed steps plus randomized ALU and mult/div
// operations checked against an arithmetic reference model.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        reset, Mi, nop_id;
    logic [1:0]  wbi;
    logic [4:0]  regaddr;
    logic [3:0]  alu_op;
    logic [31:0] opa, opb, store_data;
    logic [2:0]  md_op;
    logic [1:0]  wbo;
    logic        M, nop_exe, stall, md_busy;
    logic [31:0] data, dataaddr;
    logic [4:0]  regaddrout;

    int tests = 0;
    int fails = 0;

    exe_stage #(.ALU_OP_W(4)) dut (
        .clk(clk), .reset(reset), .wbi(wbi), .Mi(Mi), .regaddr(regaddr),
        .nop_id(nop_id), .alu_op(alu_op), .opa(opa), .opb(opb),
        .store_data(store_data), .md_op(md_op), .wbo(wbo), .M(M),
        .data(data), .dataaddr(dataaddr), .regaddrout(regaddrout),
        .nop_exe(nop_exe), .stall(stall), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] mop, input logic nop);
        alu_op = op; opa = a; opb = b; md_op = mop; nop_id = nop;
        wbi = 2'($urandom); Mi = 1'($urandom); regaddr = 5'($urandom);
        store_data = $urandom;
        #1;
    endtask

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int sh;
        logic [63:0] t;
        sa = longint'($signed(a)); sb = longint'($signed(b)); sh = int'(a[4:0]);
        case (op)
            0: t = 64'(a) + 64'(b);
            1: t = 64'(a) - 64'(b);
            2: t = 64'(a & b);
            3: t = 64'(a | b);
            4: t = 64'(a ^ b);
            5: t = 64'(~(a | b));
            6: t = (sa < sb) ? 64'd1 : 64'd0;
            7: t = (a < b) ? 64'd1 : 64'd0;
            8: t = 64'(b) * (64'd1 << sh);
            9: t = 64'(b) / (64'd1 << sh);
            10: t = 64'(sb >>> sh);
            11: t = 64'(b) * 64'd65536;
            default: t = 64'd0;
        endcase
        return t[31:0];
    endfunction

    // returns {HI, LO}
    function automatic logic [63:0] md_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = 64'(a); ub = 64'(b);
        case (op)
            1: begin p = 64'(sa * sb); return p; end
            2: return ua * ub;
            3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb; r = sa % sb;
                p = {32'(r), 32'(q)}; return p;
            end
            4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                p = {32'(ua % ub), 32'(ua / ub)}; return p;
            end
            default: return 64'd0;
        endcase
    endfunction

    // issue a mult/div, then MFHI (counting stall cycles) and MFLO
    task automatic md_run(input int op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        int n;
        exp = md_ref(op, a, b);
        drive(4'd0, a, b, 3'(op), 1'b0);
        chk({tag, "_accept_stall"}, 32'(stall), 32'd0);
        tick();
        chk({tag, "_busy"}, 32'(md_busy), 32'd1);
        drive(4'd0, 32'd0, 32'd0, 3'd5, 1'b0);
        n = 0;
        while (stall && n < 40) begin
            tick();
            chk({tag, "_stall_nop"}, 32'(nop_exe), 32'd1);
            n++;
        end
        chk({tag, "_stall_cycles"}, n, 32'd33);
        tick();
        chk({tag, "_hi"}, dataaddr, exp[63:32]);
        drive(4'd0, 32'd0, 32'd0, 3'd6, 1'b0);
        chk({tag, "_mflo_stall"}, 32'(stall), 32'd0);
        tick();
        chk({tag, "_lo"}, dataaddr, exp[31:0]);
    endtask

    initial begin
        logic [31:0] a, b, hold;
        int op;

        // reset
        reset = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 3'd0, 1'b0);
        tick();
        chk("rst_wbo", 32'(wbo), 32'd0);
        chk("rst_M", 32'(M), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_addr", dataaddr, 32'd0);
        chk("rst_rd", 32'(regaddrout), 32'd0);
        chk("rst_nop", 32'(nop_exe), 32'd1);
        chk("rst_busy", 32'(md_busy), 32'd0);
        reset = 1'b0;

        // directed ALU
        drive(4'd0, 32'h7FFF_FFFF, 32'd1, 3'd0, 1'b0);
        wbi = 2'b10; regaddr = 5'd5; store_data = 32'hCAFE_0001;
        tick();
        chk("add_res", dataaddr, 32'h8000_0000);
        chk("add_wbo", 32'(wbo), 32'd2);
        chk("add_rd", 32'(regaddrout), 32'd5);
        chk("add_nop", 32'(nop_exe), 32'd0);
        chk("add_data", data, 32'hCAFE_0001);
        drive(4'd6, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0);
        tick();
        chk("slt", dataaddr, 32'd1);
        drive(4'd7, 32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0);
        tick();
        chk("sltu", dataaddr, 32'd0);

        // randomized ALU, including unlisted codes and md_op=7
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 15));
            a = $urandom; b = $urandom;
            if (i % 4 == 0) a = $urandom_range(0, 31);
            drive(4'(op), a, b, (i % 10 == 0) ? 3'd7 : 3'd0, 1'b0);
            tick();
            chk($sformatf("alu_op%0d", op), dataaddr, alu_ref(op, a, b));
            chk("alu_nop", 32'(nop_exe), 32'd0);
        end

        // directed mult/div
        md_run(1, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        md_run(4, 32'd100, 32'd7, "divu");
        md_run(3, 32'hFFFF_FFF9, 32'd2, "div_neg");
        md_run(3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        md_run(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        md_run(3, 32'hFFFF_FFF0, 32'd0, "div_zero_s");

        // randomized mult/div
        for (int i = 0; i < 12; i++) begin
            op = int'($urandom_range(1, 4));
            a = $urandom; b = $urandom;
            if (i % 3 == 0) b = $urandom_range(0, 20);
            md_run(op, a, b, $sformatf("md_rand_op%0d", op));
        end

        // divide by zero with independent ADDs flowing underneath
        drive(4'd0, 32'd55, 32'd0, 3'd3, 1'b0);
        tick();
        for (int i = 0; i < 33; i++) begin
            a = $urandom; b = $urandom;
            drive(4'd0, a, b, 3'd0, 1'b0);
            chk("dz_add_stall", 32'(stall), 32'd0);
            tick();
            chk("dz_add_res", dataaddr, a + b);
        end
        drive(4'd0, 32'd0, 32'd0, 3'd5, 1'b0);
        chk("dz_mfhi_stall", 32'(stall), 32'd0);
        tick();
        chk("dz_hi", dataaddr, 32'd55);
        drive(4'd0, 32'd0, 32'd0, 3'd6, 1'b0);
        tick();
        chk("dz_lo", dataaddr, 32'hFFFF_FFFF);

        // bubble: store suppressed, data/addr held
        hold = dataaddr;
        a = data;
        drive(4'd0, 32'd1, 32'd2, 3'd0, 1'b1);
        Mi = 1'b1; wbi = 2'b11;
        tick();
        chk("bub_M", 32'(M), 32'd0);
        chk("bub_wbo", 32'(wbo), 32'd0);
        chk("bub_nop", 32'(nop_exe), 32'd1);
        chk("bub_rd", 32'(regaddrout), 32'd0);
        chk("bub_addr_hold", dataaddr, hold);
        chk("bub_data_hold", data, a);
        drive(4'd0, 32'd3, 32'd5, 3'd1, 1'b1);
        tick();
        chk("bub_mult_busy", 32'(md_busy), 32'd0);

        // reset mid-MULT aborts without touching HI/LO beyond clearing
        drive(4'd0, 32'd12345, 32'd678, 3'd2, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(4'd0, 32'd1, 32'd1, 3'd0, 1'b0);
            tick();
        end
        chk("pre_rst_busy", 32'(md_busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy", 32'(md_busy), 32'd0);
        chk("mrst_nop", 32'(nop_exe), 32'd1);
        drive(4'd0, 32'd0, 32'd0, 3'd6, 1'b0);
        chk("mrst_mflo_stall", 32'(stall), 32'd0);
        tick();
        chk("mrst_lo", dataaddr, 32'd0);
        drive(4'd0, 32'd0, 32'd0, 3'd5, 1'b0);
        tick();
        chk("mrst_hi", dataaddr, 32'd0);
        // a few more edges confirm nothing completes late
        for (int i = 0; i < 30; i++) begin
            drive(4'd0, 32'd0, 32'd0, 3'd6, 1'b0);
            tick();
        end
        chk("mrst_lo_late", dataaddr, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
